// File: rtl/vanilla_pc_sequencer.sv
// vanilla_pc_sequencer: in-order fetch PC sequencer with redirect and wrong-path squash.
module vanilla_pc_sequencer #(
    parameter int pc_width_p        = 22,
    parameter int max_outstanding_p = 4,
    parameter int cnt_width_p       = $clog2(max_outstanding_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [pc_width_p-1:0] pc_init_i,
    input  logic                  freeze_i,
    input  logic                  stall_i,
    output logic                  fetch_v_o,
    output logic [pc_width_p-1:0] fetch_pc_o,
    input  logic                  fetch_ready_i,
    input  logic                  imem_v_i,
    input  logic [31:0]           imem_instr_i,
    output logic                  instr_v_o,
    output logic [31:0]           instr_o,
    output logic [pc_width_p-1:0] instr_pc_o,
    output logic [31:0]           instr_pc_next_o,
    input  logic                  exe_v_i,
    input  logic                  exe_is_branch_i,
    input  logic                  exe_is_jump_i,
    input  logic                  exe_jump_now_i,
    input  logic [pc_width_p-1:0] exe_branch_target_i,
    input  logic                  exe_is_jalr_i,
    input  logic [pc_width_p-1:0] exe_jalr_addr_i,
    output logic                  flush_o,
    output logic                  idle_o
);
    localparam logic [1:0] state_reset  = 2'd0;
    localparam logic [1:0] state_run    = 2'd1;
    localparam logic [1:0] state_frozen = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [pc_width_p-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, shadow_q, shadow_d;
    logic [cnt_width_p-1:0] outstanding_q, outstanding_d, squash_q, squash_d;
    logic                  running, redirect, issue, ret;
    logic [pc_width_p-1:0] target;

    always_comb begin
        running       = state_q != state_reset;
        redirect      = running & exe_v_i & ((exe_is_branch_i & exe_jump_now_i) | exe_is_jump_i);
        target        = exe_is_jalr_i ? exe_jalr_addr_i : exe_branch_target_i;
        fetch_v_o     = (state_q == state_run) & ~freeze_i & ~stall_i
                        & (outstanding_q < cnt_width_p'(max_outstanding_p));
        issue         = fetch_v_o & fetch_ready_i;
        ret           = imem_v_i;
        state_d       = (state_q == state_reset) ? state_run : freeze_i ? state_frozen : state_run;
        pc_d          = redirect ? target : pc_q + pc_width_p'(issue);
        outstanding_d = outstanding_q + cnt_width_p'(issue) - cnt_width_p'(ret);
        squash_d      = redirect ? outstanding_d : squash_q - cnt_width_p'(ret && squash_q != '0);
        shadow_d      = redirect ? target : shadow_q;
        // the redirect target becomes the tagged PC only once every wrong-path response is gone
        resp_pc_d     = redirect ? ((outstanding_d == '0) ? target : resp_pc_q)
                      : !ret ? resp_pc_q
                      : (squash_q == cnt_width_p'(1)) ? shadow_q
                      : (squash_q == '0) ? resp_pc_q + pc_width_p'(1) : resp_pc_q;
        flush_o         = redirect;
        idle_o          = (state_q == state_frozen) & (outstanding_q == '0);
        fetch_pc_o      = pc_q;
        instr_v_o       = running & imem_v_i & (squash_q == '0) & ~redirect;
        instr_o         = running ? imem_instr_i : '0;
        instr_pc_o      = running ? resp_pc_q : '0;
        instr_pc_next_o = running ? 32'({resp_pc_q + pc_width_p'(1), 2'b00}) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= state_reset;
            pc_q          <= pc_init_i;
            resp_pc_q     <= pc_init_i;
            shadow_q      <= '0;
            outstanding_q <= '0;
            squash_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            shadow_q      <= shadow_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
        end
    end

    always_ff @(posedge clk_i)
        if (!reset_i && imem_v_i)
            assert (outstanding_q != '0);
endmodule

// File: tb/tb_vanilla_pc_sequencer.sv
// tb_vanilla_pc_sequencer: directed vector table, reset sequence and random run against a queue model.
module tb_vanilla_pc_sequencer;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        reset_i, freeze_i, stall_i, fetch_ready_i, imem_v_i;
    logic [21:0] pc_init_i, exe_branch_target_i, exe_jalr_addr_i;
    logic [31:0] imem_instr_i;
    logic        exe_v_i, exe_is_branch_i, exe_is_jump_i, exe_jump_now_i, exe_is_jalr_i;
    logic        fetch_v_o, instr_v_o, flush_o, idle_o;
    logic [21:0] fetch_pc_o, instr_pc_o;
    logic [31:0] instr_o, instr_pc_next_o;

    vanilla_pc_sequencer dut (
        .clk_i(clk_i), .reset_i(reset_i), .pc_init_i(pc_init_i),
        .freeze_i(freeze_i), .stall_i(stall_i),
        .fetch_v_o(fetch_v_o), .fetch_pc_o(fetch_pc_o), .fetch_ready_i(fetch_ready_i),
        .imem_v_i(imem_v_i), .imem_instr_i(imem_instr_i),
        .instr_v_o(instr_v_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_pc_next_o(instr_pc_next_o),
        .exe_v_i(exe_v_i), .exe_is_branch_i(exe_is_branch_i), .exe_is_jump_i(exe_is_jump_i),
        .exe_jump_now_i(exe_jump_now_i), .exe_branch_target_i(exe_branch_target_i),
        .exe_is_jalr_i(exe_is_jalr_i), .exe_jalr_addr_i(exe_jalr_addr_i),
        .flush_o(flush_o), .idle_o(idle_o)
    );

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [21:0] pc;
        bit          live;
    } ent_t;

    ent_t        m_q[$];
    logic [21:0] m_pc;
    bit          m_started, m_frozen;

    typedef struct {
        logic        fz, st, rdy, iv, ev, br, jp, jn, jr;
        logic [21:0] tgt, ja;
        logic        fv;
        logic [21:0] fpc;
        logic        ivo;
        logic [21:0] ipc;
        logic        fl, idl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [8:0] in_bits, logic [21:0] tgt, logic [21:0] ja,
                                logic fv, logic [21:0] fpc, logic ivo, logic [21:0] ipc,
                                logic fl, logic idl);
        vec_t v;
        {v.fz, v.st, v.rdy, v.iv, v.ev, v.br, v.jp, v.jn, v.jr} = in_bits;
        v.tgt = tgt; v.ja = ja; v.fv = fv; v.fpc = fpc;
        v.ivo = ivo; v.ipc = ipc; v.fl = fl; v.idl = idl;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        freeze_i = 0; stall_i = 0; fetch_ready_i = 0; imem_v_i = 0; imem_instr_i = '0;
        exe_v_i = 0; exe_is_branch_i = 0; exe_is_jump_i = 0; exe_jump_now_i = 0;
        exe_is_jalr_i = 0; exe_branch_target_i = '0; exe_jalr_addr_i = '0;
    endtask

    // Checks outputs against the in-flight queue model, then advances model and DUT one clock.
    task automatic finish_cycle();
        bit fv, fl, iv;
        if (!reset_i) begin
            fv = m_started && !m_frozen && !freeze_i && !stall_i && m_q.size() < 4;
            fl = m_started && exe_v_i && ((exe_is_branch_i && exe_jump_now_i) || exe_is_jump_i);
            iv = m_started && imem_v_i && m_q.size() > 0 && m_q[0].live && !fl;
            chk("m_fetch_v", fetch_v_o, fv);
            chk("m_fetch_pc", fetch_pc_o, m_pc);
            chk("m_flush", flush_o, fl);
            chk("m_idle", idle_o, m_started && m_frozen && m_q.size() == 0);
            chk("m_instr_v", instr_v_o, iv);
            if (iv) begin
                chk("m_instr_pc", instr_pc_o, m_q[0].pc);
                chk("m_instr_pc_next", instr_pc_next_o, {m_q[0].pc + 22'd1, 2'b00});
                chk("m_instr", instr_o, imem_instr_i);
            end
            if (!m_started) begin
                chk("m_rst_instr_pc", instr_pc_o, 0);
                chk("m_rst_instr_pc_next", instr_pc_next_o, 0);
            end
            if (imem_v_i && m_q.size() > 0) void'(m_q.pop_front());
            if (fl) foreach (m_q[i]) m_q[i].live = 0;
            if (fv && fetch_ready_i) m_q.push_back('{pc: m_pc, live: !fl});
            m_pc = fl ? (exe_is_jalr_i ? exe_jalr_addr_i : exe_branch_target_i)
                      : m_pc + 22'(fv && fetch_ready_i);
            if (!m_started) m_started = 1;
            else m_frozen = freeze_i;
        end else begin
            m_q.delete();
            m_pc = pc_init_i;
            m_started = 0;
            m_frozen = 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // {fz,st,rdy,iv,ev,br,jp,jn,jr}, tgt, ja | fetch_v, fetch_pc, instr_v, instr_pc, flush, idle
        vecs.push_back(mk(9'b001000000, 0, 0, 0, 22'h100, 0, 0, 0, 0));
        vecs.push_back(mk(9'b001000000, 0, 0, 1, 22'h100, 0, 0, 0, 0));
        vecs.push_back(mk(9'b001100000, 0, 0, 1, 22'h101, 1, 22'h100, 0, 0));
        vecs.push_back(mk(9'b001100000, 0, 0, 1, 22'h102, 1, 22'h101, 0, 0));
        vecs.push_back(mk(9'b001100000, 0, 0, 1, 22'h103, 1, 22'h102, 0, 0));
        vecs.push_back(mk(9'b001100000, 0, 0, 1, 22'h104, 1, 22'h103, 0, 0));
        vecs.push_back(mk(9'b001000000, 0, 0, 1, 22'h105, 0, 0, 0, 0));
        vecs.push_back(mk(9'b001000000, 0, 0, 1, 22'h106, 0, 0, 0, 0));
        vecs.push_back(mk(9'b001000000, 0, 0, 1, 22'h107, 0, 0, 0, 0));
        vecs.push_back(mk(9'b001000000, 0, 0, 0, 22'h108, 0, 0, 0, 0));
        vecs.push_back(mk(9'b001100000, 0, 0, 0, 22'h108, 1, 22'h104, 0, 0));
        vecs.push_back(mk(9'b000000000, 0, 0, 1, 22'h108, 0, 0, 0, 0));
        vecs.push_back(mk(9'b000111010, 22'h200, 0, 1, 22'h108, 0, 0, 1, 0));
        vecs.push_back(mk(9'b001100000, 0, 0, 1, 22'h200, 0, 0, 0, 0));
        vecs.push_back(mk(9'b000100000, 0, 0, 1, 22'h201, 0, 0, 0, 0));
        vecs.push_back(mk(9'b000100000, 0, 0, 1, 22'h201, 1, 22'h200, 0, 0));
        vecs.push_back(mk(9'b001010101, 22'h010, 22'h3FF, 1, 22'h201, 0, 0, 1, 0));
        vecs.push_back(mk(9'b001100000, 0, 0, 1, 22'h3FF, 0, 0, 0, 0));
        vecs.push_back(mk(9'b001111000, 22'h010, 0, 1, 22'h400, 1, 22'h3FF, 0, 0));
        vecs.push_back(mk(9'b001000000, 0, 0, 1, 22'h401, 0, 0, 0, 0));
        vecs.push_back(mk(9'b101000000, 0, 0, 0, 22'h402, 0, 0, 0, 0));
        vecs.push_back(mk(9'b101100000, 0, 0, 0, 22'h402, 1, 22'h400, 0, 0));
        vecs.push_back(mk(9'b101100000, 0, 0, 0, 22'h402, 1, 22'h401, 0, 0));
        vecs.push_back(mk(9'b101000000, 0, 0, 0, 22'h402, 0, 0, 0, 1));
        vecs.push_back(mk(9'b001000000, 0, 0, 0, 22'h402, 0, 0, 0, 1));
        vecs.push_back(mk(9'b001000000, 0, 0, 1, 22'h402, 0, 0, 0, 0));
        vecs.push_back(mk(9'b011100000, 0, 0, 0, 22'h403, 1, 22'h402, 0, 0));

        clear_inputs();
        reset_i = 1; pc_init_i = 22'h100;
        finish_cycle();
        finish_cycle();
        reset_i = 0;

        foreach (vecs[i]) begin
            {freeze_i, stall_i, fetch_ready_i, imem_v_i, exe_v_i, exe_is_branch_i,
             exe_is_jump_i, exe_jump_now_i, exe_is_jalr_i} =
                {vecs[i].fz, vecs[i].st, vecs[i].rdy, vecs[i].iv, vecs[i].ev, vecs[i].br,
                 vecs[i].jp, vecs[i].jn, vecs[i].jr};
            exe_branch_target_i = vecs[i].tgt;
            exe_jalr_addr_i = vecs[i].ja;
            imem_instr_i = $urandom;
            #3;
            chk($sformatf("v%0d_fetch_v", i), fetch_v_o, vecs[i].fv);
            chk($sformatf("v%0d_fetch_pc", i), fetch_pc_o, vecs[i].fpc);
            chk($sformatf("v%0d_instr_v", i), instr_v_o, vecs[i].ivo);
            chk($sformatf("v%0d_flush", i), flush_o, vecs[i].fl);
            chk($sformatf("v%0d_idle", i), idle_o, vecs[i].idl);
            if (vecs[i].ivo) begin
                chk($sformatf("v%0d_instr_pc", i), instr_pc_o, vecs[i].ipc);
                chk($sformatf("v%0d_instr_pc_next", i), instr_pc_next_o, {vecs[i].ipc + 22'd1, 2'b00});
            end
            finish_cycle();
        end

        // reset pulse with three fetches in flight
        clear_inputs();
        fetch_ready_i = 1;
        repeat (3) begin
            #3;
            finish_cycle();
        end
        fetch_ready_i = 0; reset_i = 1; pc_init_i = 22'h040;
        #3;
        finish_cycle();
        reset_i = 0; fetch_ready_i = 1;
        exe_v_i = 1; exe_is_jump_i = 1; exe_branch_target_i = 22'h055;
        #3;
        chk("rst_fetch_v", fetch_v_o, 0);
        chk("rst_fetch_pc", fetch_pc_o, 22'h040);
        chk("rst_flush", flush_o, 0);
        chk("rst_instr_v", instr_v_o, 0);
        chk("rst_instr_pc", instr_pc_o, 0);
        chk("rst_instr_pc_next", instr_pc_next_o, 0);
        chk("rst_idle", idle_o, 0);
        finish_cycle();
        clear_inputs(); fetch_ready_i = 1;
        #3;
        chk("post_rst_fetch_v", fetch_v_o, 1);
        chk("post_rst_fetch_pc", fetch_pc_o, 22'h040);
        finish_cycle();

        clear_inputs();
        reset_i = 1; pc_init_i = 22'($urandom);
        #3;
        finish_cycle();
        for (int c = 0; c < 4000; c++) begin
            reset_i = ($urandom_range(199) == 0);
            if (reset_i) pc_init_i = 22'($urandom);
            if ($urandom_range(19) == 0) freeze_i = ~freeze_i;
            stall_i = ($urandom_range(4) == 0);
            fetch_ready_i = ($urandom_range(9) < 7);
            imem_v_i = !reset_i && m_q.size() > 0 && $urandom_range(1) == 1;
            imem_instr_i = $urandom;
            exe_v_i = ($urandom_range(3) == 0);
            exe_is_branch_i = $urandom_range(1) == 1;
            exe_is_jump_i = ($urandom_range(3) == 0);
            exe_jump_now_i = $urandom_range(1) == 1;
            exe_is_jalr_i = $urandom_range(1) == 1;
            exe_branch_target_i = 22'($urandom);
            exe_jalr_addr_i = 22'($urandom);
            #3;
            finish_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vanilla_pc_sequencer.md
Name: vanilla_pc_sequencer

Overview:
- Fetch-side PC sequencer for the vanilla core. It owns the word-addressed PC and issues in-order instruction fetch requests.
- It supplies each returned instruction with its byte-address pc_next. This value feeds the execute stage's pc_next_i.
- It consumes the execute stage's jump_now, jalr address and branch target to redirect fetch, squashing all wrong-path responses still in flight.

Parameters:
pc_width_p, 22, word-address PC width; must be <= 30
max_outstanding_p, 4, maximum fetch requests in flight (>= 1)
cnt_width_p, $clog2(max_outstanding_p+1), outstanding/squash counter width (derived)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
pc_init_i  in  pc_width_p  word PC loaded at reset
freeze_i  in  1  stop issuing fetches; drain in-flight requests
stall_i  in  1  decode stall; blocks new fetch issue only
fetch_v_o  out  1  fetch request valid
fetch_pc_o  out  pc_width_p  fetch word address
fetch_ready_i  in  1  fetch request accepted when fetch_v_o & fetch_ready_i
imem_v_i  in  1  fetch response valid (in order, always accepted)
imem_instr_i  in  32  fetched instruction
instr_v_o  out  1  non-squashed instruction valid to decode
instr_o  out  32  instruction
instr_pc_o  out  pc_width_p  word PC of instr_o
instr_pc_next_o  out  32  byte address {instr_pc_o+1, 2'b00}, zero-extended
exe_v_i  in  1  execute-stage instruction valid
exe_is_branch_i  in  1  execute instruction is a conditional branch
exe_is_jump_i  in  1  execute instruction is JAL/JALR
exe_jump_now_i  in  1  branch-taken result from the ALU
exe_branch_target_i  in  pc_width_p  branch/JAL word target
exe_is_jalr_i  in  1  select exe_jalr_addr_i as target
exe_jalr_addr_i  in  pc_width_p  JALR word target from the ALU
flush_o  out  1  combinational: redirect this cycle; kill decode stage
idle_o  out  1  frozen and zero outstanding

Behaviour:
- Reset (synchronous, reset_i high at clk_i edge):
  - pc_q <= pc_init_i; outstanding_q = 0; squash_q = 0; state = RESET.
  - All outputs are 0, except fetch_pc_o = pc_q.
- FSM states: RESET, RUN, FROZEN.
  - RESET -> RUN unconditionally on the next cycle. No fetch is issued in RESET.
  - RUN -> FROZEN when freeze_i = 1.
  - FROZEN -> RUN when freeze_i = 0.
  - idle_o = (state == FROZEN) & (outstanding_q == 0).
- Fetch issue: fetch_v_o = (state == RUN) & ~freeze_i & ~stall_i & (outstanding_q < max_outstanding_p).
  - fetch_pc_o = pc_q.
  - On handshake, pc_q <= pc_q + 1. Wrap-around modulo 2^pc_width_p is allowed.
- Redirect condition: exe_v_i & ((exe_is_branch_i & exe_jump_now_i) | exe_is_jump_i).
  - When it holds, flush_o = 1 in the same cycle.
  - pc_q <= exe_is_jalr_i ? exe_jalr_addr_i : exe_branch_target_i. This overrides any increment from the same cycle.
  - A fetch handshake in the redirect cycle still counts as issued, and becomes wrong-path.
  - Not-taken branches cause no action (static not-taken prediction).
- Counters, with issue = fetch handshake and ret = imem_v_i:
  - outstanding_q <= outstanding_q + issue - ret.
  - ret with outstanding_q == 0 is illegal; assert on it.
- Squash:
  - On redirect: squash_q <= outstanding_q + issue - ret. The response arriving in the redirect cycle is itself dropped.
  - Otherwise, squash_q decrements by 1 on each ret while squash_q > 0.
  - instr_v_o = imem_v_i & (squash_q == 0) & ~redirect.
- Response tagging:
  - A response PC register tracks the word PC of the next expected response.
  - It loads pc_init_i at reset and increments on each ret.
  - On redirect it loads the redirect target, but takes effect only after squash_q drains. A shadow register holds the target until squash_q reaches 0.
  - instr_pc_o = tracked PC; instr_pc_next_o = ({instr_pc_o, 2'b00} + 4), zero-extended to 32.
- Back-to-back redirects: a second redirect while squash_q > 0 recomputes squash_q from the current outstanding count. The newest target wins.
- freeze_i does not block responses or redirects. A redirect in FROZEN updates pc_q; fetch resumes at the target once unfrozen.
- Reset mid-operation: all in-flight responses are forgotten.
  - The environment must not return responses after reset for pre-reset requests.

Test Plan:
- Straight-line: pc_init_i=0x100, fetch_ready_i=1, 1-cycle memory -> fetch_pc_o 0x100, 0x101, 0x102…; instr_pc_next_o 0x408, 0x40C for PCs 0x101, 0x102.
- Outstanding cap: fetch_ready_i=1, no responses -> exactly 4 handshakes, then fetch_v_o=0 until one imem_v_i.
- Taken branch: 3 outstanding, exe_jump_now_i=1, target 0x200, a response arrives in the same cycle -> flush_o=1, squash_q=2, next 2 responses dropped; next delivered instr_pc_o=0x200.
- JALR vs branch: exe_is_jalr_i=1, exe_jalr_addr_i=0x3FF, exe_branch_target_i=0x10 -> next fetch_pc_o=0x3FF. Not-taken branch -> no flush, PC sequence unchanged.
- Freeze/drain: freeze_i=1 with 2 outstanding -> no fetches; idle_o=1 after 2 responses; unfreeze resumes at the held pc_q.
- Reset mid-stream: reset_i pulsed with 3 outstanding, pc_init_i=0x40 -> outputs cleared; first post-reset fetch at 0x40 two cycles later.
